// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared FIFO constants, width helper and parameter check macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    // Defaults shared with async_fifo so both FIFOs build with identical geometry
    localparam int c_default_data_width = 8;
    localparam int c_default_depth      = 16;

    function automatic int fifo_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit fifo_params_ok(input int depth, input int af, input int ae);
        bit pow2;
        pow2 = (depth > 0) && ((depth & (depth - 1)) == 0);
        return pow2 && (depth >= 4) && (af >= 1) && (af <= depth)
               && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

`define FIFO_PARAM_CHECK(D, AF, AE) \
    if (!fifo_pkg::fifo_params_ok(D, AF, AE)) begin : g_param_err \
        $error("fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL combination"); \
    end

`default_nettype wire

// File: rtl/fifo_ram.sv
// ============================================================================
// Module      : fifo_ram
// Description : Simple dual-port array; sync write, sync or combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter bit SYNC_READ  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Storage is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_addr] <= wr_data;
    end

    generate
        if (SYNC_READ) begin : g_sync_rd
            logic [DATA_WIDTH-1:0] r_rd_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data <= '0;
                end else if (rd_en) begin
                    r_rd_data <= r_mem[rd_addr];
                end
            end

            assign rd_data = r_rd_data;
        end else begin : g_comb_rd
            logic w_unused_rd_ctrl;

            assign w_unused_rd_ctrl = rst & rd_en;
            assign rd_data          = r_mem[rd_addr];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Single-clock FIFO with thresholds, occupancy and sticky errors.
//               Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int DEPTH      = c_default_depth,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int c_ptr_w = fifo_clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0] c_depth    = DEPTH[c_cnt_w-1:0];
    localparam logic [c_cnt_w-1:0] c_af_level = AF_LEVEL[c_cnt_w-1:0];
    localparam logic [c_cnt_w-1:0] c_ae_level = AE_LEVEL[c_cnt_w-1:0];

`ifdef SYNC_FIFO_FWFT_EN
    localparam bit c_sync_read = 1'b0;
`else
    localparam bit c_sync_read = 1'b1;
`endif

    `FIFO_PARAM_CHECK(DEPTH, AF_LEVEL, AE_LEVEL)

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_almost_full;
    logic               r_almost_empty;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_rd_acc;
    logic               w_wr_acc;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign w_rd_acc = rd_en & ~r_empty;
    assign w_wr_acc = wr_en & (~r_full | w_rd_acc);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_depth);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_af_level);
            r_almost_empty <= (w_count_nxt <= c_ae_level);
            r_overflow     <= r_overflow  | (wr_en & ~w_wr_acc);
            r_underflow    <= r_underflow | (rd_en & ~w_rd_acc);
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (c_ptr_w),
        .SYNC_READ  (c_sync_read)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr),
        .wr_data (din),
        .rd_en   (w_rd_acc),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    assign dout         = w_rd_data;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Parametrised single-clock FIFO; successor to the team's dual-clock async_fifo, for paths where producer and consumer share one clock.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.
- Sits between streaming producer/consumer blocks as an elastic buffer.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- DEPTH, 16, number of entries; must be a power of 2 and ≥ 4.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data.
- full  out  1  no free entry.
- empty  out  1  no stored entry.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was rejected.
- underflow  out  1  sticky; a read was rejected.

Behaviour:
- Reset (rst=1 at a clock edge), values:
  - wr_ptr, rd_ptr, count = 0
  - empty = 1, full = 0
  - almost_empty = 1, almost_full = 0
  - dout = 0
  - overflow = 0, underflow = 0
  - RAM contents are not cleared.
- Reset mid-operation discards all stored data; rst has priority over wr_en/rd_en in the same cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Read accepted: rd_acc = rd_en & !empty.
- Write accepted: wr_acc = wr_en & (!full | rd_acc).
  - A write to a full FIFO succeeds only when a read is accepted in the same cycle.
- When empty, a simultaneous write and read: the write is accepted, the read is rejected, and underflow is set.
- Count update:
  - +1 if wr_acc only.
  - -1 if rd_acc only.
  - Unchanged if both or neither.
- All status outputs are registered and computed from the next count. They reflect the new occupancy one edge after the access.
  - Write into an empty FIFO: empty falls at the same edge that stores the word.
- Standard read mode: on rd_acc, dout <= mem[rd_ptr] at that edge, so data is valid the cycle after rd_en. dout holds its value otherwise.
- overflow sets on wr_en & !wr_acc; underflow sets on rd_en & !rd_acc. Both are cleared only by rst.
- Rejected accesses change no pointer, count, or data.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout continuously presents mem[rd_ptr] whenever empty=0, with no registered read stage.
  - rd_en acknowledges and pops the presented word.
  - The first written word appears on dout in the same cycle empty falls.
  - dout is don't-care while empty=1.
- Undefined: standard registered read as above.
- Flag and count behaviour is identical in both modes.

Decomposition:
- Package fifo_pkg:
  - clog2-style width function.
  - Default DATA_WIDTH/DEPTH constants shared with async_fifo.
  - Parameter-legality check macro (power-of-2 depth, threshold ranges).
- Sub-module fifo_ram: simple dual-port array.
  - One synchronous write port.
  - Read port synchronous or combinational, selected by a parameter driven from SYNC_FIFO_FWFT_EN.
- Pointer, count, and flag logic stay in sync_fifo_ctrl.

Test Plan:
1. Reset check: hold rst 2 cycles with wr_en=rd_en=1 -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0, dout=0.
2. Basic ordering: write 0x01..0x04 on consecutive cycles, then read 4 -> dout 0x01,0x02,0x03,0x04, each one cycle after rd_en; count 4→0; empty=1 after the last read.
3. Fill and overflow: write 17 words into DEPTH=16 -> full=1 at count=16, almost_full=1 from count=14, 17th write rejected, overflow=1 and stays 1; read 16 -> data 1..16, no loss.
4. Simultaneous access:
   - At full, wr_en=rd_en=1 -> both accepted, count stays 16, no overflow.
   - At empty, both asserted -> write accepted, count=1, underflow=1.
5. Wrap-around: 40 cycles of interleaved write/read at occupancy 3 -> pointers wrap twice, data order preserved, almost_empty tracks count ≤ 2.
6. Mode and reset: with SYNC_FIFO_FWFT_EN, write 0xA5 -> dout=0xA5 in the same cycle empty falls. Assert rst mid-burst at count=7 -> count=0 next edge, subsequent reads return only post-reset data.
